csa_mult_8bits: RTL and testbench
=================================

CSA_MULT_8BITS -- requirements
Module: csa_mult_8bits

Interface
REQ-001 Parameter HBL, default 2: horizontal break level; partial-product rows b[0..HBL-1] are omitted.
REQ-002 Parameter VBL, default 6: vertical break level; partial-product bits in columns i+j < VBL are omitted.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port A, input, 8 bits: unsigned multiplicand.
REQ-006 Port B, input, 8 bits: unsigned multiplier.
REQ-007 Port P, output, 16 bits: registered unsigned approximate product.

Function
REQ-008 The block SHALL implement a broken-array (BAM) carry-save array multiplier.
- Partial product pp[i][j] = A[i] & B[j], weight 2^(i+j), i,j in 0..7.
REQ-009 pp[i][j] SHALL be kept only if j >= HBL and i+j >= VBL; all other bits are treated as constant 0.
- Their adder cells are removed, not merely gated.
REQ-010 The approximate result SHALL equal the exact unsigned sum of all kept pp[i][j]·2^(i+j).
- Reduction: carry-save rows of full/half adders, then a final ripple-carry adder.
- No carry truncation beyond the omitted bits.
- The result always fits in 16 bits; no overflow or wrap.
REQ-011 Timing: A and B are combinational into the array.
- P SHALL be registered and updated on every rising clk edge with the product of the A,B present before that edge.
- Latency is 1 cycle; a new operand pair is accepted every cycle.
REQ-012 There is no handshake, no valid signal and no enable; P SHALL be recomputed every cycle.
REQ-013 Error properties: P <= A*B for all inputs, and P SHALL equal A*B whenever no nonzero pp falls in an omitted row or column.
REQ-014 The array SHALL be unsigned only; no sign extension.

Reset
REQ-015 While rst_n = 0, P SHALL be 16'h0000, asynchronously, regardless of clk.
REQ-016 On rst_n deassertion, P SHALL hold 0 until the first rising clk edge with rst_n = 1, then follow REQ-011.
REQ-017 Reset asserted mid-stream SHALL clear P immediately.
- The first output after release SHALL reflect the operands sampled at the first post-release edge.

Verification
REQ-018 A=255, B=255 -> P=64064 one edge later (exact 65025, error 961).
REQ-019 Row break: A=255, B=3 -> P=0 (exact 765).
- A=0 with any B, and any A with B=0 -> P=0.
REQ-020 Column boundary:
- A=2, B=4 -> P=0 (column 3 dropped).
- A=16, B=4 -> P=64 (column 6 kept, exact).
- A=1, B=128 -> P=128 (exact).
REQ-021 Pipelining: apply (255,255), then (16,4), then (1,128) on consecutive edges -> P sequence 64064, 64, 128 with 1-cycle latency.
REQ-022 Reset: drive rst_n low between edges while P=64064 -> P=0 immediately.
- P stays 0 while rst_n is low; first edge after release with A=16, B=4 -> P=64.
REQ-023 Random sweep: 10000 random A,B against a golden model per REQ-010.
- Require an exact match.
- Require P <= A*B in every case.
- Report ER, MED, MRED, NMED (normalised by 65025) and max error distance; max error distance SHALL be <= 961.

Source files
------------

// File: rtl/csa_mult_8bits.sv
// Broken-array (BAM) unsigned 8x8 carry-save array multiplier with a registered product.
// Rows below HBL and columns below VBL are never built; the result is the exact sum of the kept partial products.
module csa_mult_8bits #(
    parameter int HBL = 2,
    parameter int VBL = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P
);

    // Carry-save state after each row: sum_s[j] + carry_s[j] is the running partial sum.
    logic [8:0][15:0] sum_s;
    logic [8:0][15:0] carry_s;
    logic [7:0][15:0] pp_s;
    logic [15:0]      rc_s;
    logic [15:0]      p_d;
    logic [15:0]      p_q;
    logic             unused_inputs_s;

    assign sum_s[0]   = 16'h0000;
    assign carry_s[0] = 16'h0000;

    for (genvar j = 0; j < 8; j++) begin : g_row
        if (j < HBL) begin : g_row_omit
            assign pp_s[j]      = 16'h0000;
            assign sum_s[j+1]   = sum_s[j];
            assign carry_s[j+1] = carry_s[j];
        end else begin : g_row_keep
            assign carry_s[j+1][0] = 1'b0;
            for (genvar k = 0; k < 16; k++) begin : g_col
                localparam bit KEEP = (k >= VBL) && (k >= j) && (k - j <= 7);
                if (KEEP) begin : g_fa
                    assign pp_s[j][k]    = A[k-j] & B[j];
                    assign sum_s[j+1][k] = sum_s[j][k] ^ carry_s[j][k] ^ pp_s[j][k];
                    if (k < 15) begin : g_cout
                        assign carry_s[j+1][k+1] = (sum_s[j][k] & carry_s[j][k]) |
                                                   (sum_s[j][k] & pp_s[j][k]) |
                                                   (carry_s[j][k] & pp_s[j][k]);
                    end
                end else begin : g_ha
                    assign pp_s[j][k]    = 1'b0;
                    assign sum_s[j+1][k] = sum_s[j][k] ^ carry_s[j][k];
                    if (k < 15) begin : g_cout
                        assign carry_s[j+1][k+1] = sum_s[j][k] & carry_s[j][k];
                    end
                end
            end
        end
    end

    // Final ripple-carry merge; no carry can leave bit 15 since the true sum fits in 16 bits.
    assign rc_s[0] = 1'b0;
    for (genvar k = 0; k < 16; k++) begin : g_rca
        assign p_d[k] = sum_s[8][k] ^ carry_s[8][k] ^ rc_s[k];
        if (k < 15) begin : g_rc
            assign rc_s[k+1] = (sum_s[8][k] & carry_s[8][k]) |
                               (sum_s[8][k] & rc_s[k]) |
                               (carry_s[8][k] & rc_s[k]);
        end
    end

    // Operand bits feeding only omitted cells are intentionally left dangling.
    assign unused_inputs_s = ^{A, B, pp_s};

    // Product register: one-cycle latency, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= 16'h0000;
        end else begin
            p_q <= p_d;
        end
    end

    assign P = p_q;

endmodule

// File: tb/tb_csa_mult_8bits.sv
// Self-checking bench for csa_mult_8bits: directed table, pipeline/reset sequences, random sweep vs. a BAM model.
module tb_csa_mult_8bits;

    localparam int HBL = 2;
    localparam int VBL = 6;

    logic        clk;
    logic        rst_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;

    int total;
    int bad;

    csa_mult_8bits #(.HBL(HBL), .VBL(VBL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        string       name;
    } vec_t;

    // Golden model: sum of the kept partial products with plain integer arithmetic.
    function automatic int bam_ref(input int a, input int b);
        int acc;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (j >= HBL && (i + j) >= VBL && ((a >> i) & 1) == 1 && ((b >> j) & 1) == 1) begin
                    acc += (1 << (i + j));
                end
            end
        end
        return acc;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];
    int   ed;
    int   exact;
    int   n_err;
    int   max_ed;
    real  sum_ed;
    real  sum_red;
    int   ra;
    int   rb;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        A     = 8'd0;
        B     = 8'd0;

        vecs[0] = '{8'd255, 8'd255, 16'd64064, "max_operands"};
        vecs[1] = '{8'd255, 8'd3,   16'd0,     "row_break"};
        vecs[2] = '{8'd0,   8'd200, 16'd0,     "a_zero"};
        vecs[3] = '{8'd173, 8'd0,   16'd0,     "b_zero"};
        vecs[4] = '{8'd2,   8'd4,   16'd0,     "col3_dropped"};
        vecs[5] = '{8'd16,  8'd4,   16'd64,    "col6_kept"};
        vecs[6] = '{8'd1,   8'd128, 16'd128,   "a1_b128"};
        vecs[7] = '{8'd12,  8'd12,  16'd64,    "mixed_cols"};
        vecs[8] = '{8'd128, 8'd255, 16'd32256, "a128_full_b"};

        #1;
        check("reset_async", P, 0);
        @(posedge clk);
        #1;
        check("reset_hold_clk", P, 0);
        @(negedge clk);
        A = 8'd255;
        B = 8'd255;
        rst_n = 1'b1;
        #1;
        check("release_before_edge", P, 0);
        @(posedge clk);
        #1;
        check("first_edge_after_release", P, 64064);

        for (int v = 0; v < 9; v++) begin
            apply(vecs[v].a, vecs[v].b);
            check(vecs[v].name, P, vecs[v].p);
        end

        // Back-to-back operands: each edge shows the pair applied just before it.
        @(negedge clk);
        A = 8'd255; B = 8'd255;
        @(negedge clk);
        check("pipe_0", P, 64064);
        A = 8'd16; B = 8'd4;
        @(negedge clk);
        check("pipe_1", P, 64);
        A = 8'd1; B = 8'd128;
        @(negedge clk);
        check("pipe_2", P, 128);

        // Mid-stream reset between edges.
        apply(8'd255, 8'd255);
        check("pre_reset_value", P, 64064);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_stream", P, 0);
        @(posedge clk);
        #1;
        check("reset_held_low", P, 0);
        @(negedge clk);
        A = 8'd16;
        B = 8'd4;
        rst_n = 1'b1;
        #1;
        check("post_release_hold", P, 0);
        @(posedge clk);
        #1;
        check("post_release_first", P, 64);

        // Random sweep with error statistics.
        n_err   = 0;
        max_ed  = 0;
        sum_ed  = 0.0;
        sum_red = 0.0;
        for (int n = 0; n < 10000; n++) begin
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            apply(ra[7:0], rb[7:0]);
            check("rand_exact", P, bam_ref(ra, rb));
            exact = ra * rb;
            total++;
            if (int'(P) > exact) begin
                bad++;
                $display("FAIL rand_bound: got %0d above exact %0d (A=%0d B=%0d)", P, exact, ra, rb);
            end
            ed = exact - int'(P);
            if (ed != 0) n_err++;
            if (ed > max_ed) max_ed = ed;
            sum_ed += real'(ed);
            if (exact > 0) sum_red += real'(ed) / real'(exact);
        end
        check("max_error_distance_cap", (max_ed <= 961) ? 1 : 0, 1);
        $display("stats: ER=%f MED=%f MRED=%f NMED=%f maxED=%0d",
                 real'(n_err) / 10000.0, sum_ed / 10000.0, sum_red / 10000.0,
                 (sum_ed / 10000.0) / 65025.0, max_ed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
